// File: rtl/atomrvcore_loader_pkg.sv
// Shared types and framing constants for the ICCM boot loader.
// Checksum tail state is used only when ATOMRV_LOADER_CHECKSUM_EN is defined.
package atomrvcore_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/atomrvcore_word_packer.sv
// Little-endian byte-to-word assembler shared by the length and data phases.
// word presents the assembled value including the byte being strobed.
import atomrvcore_loader_pkg::*;

module atomrvcore_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  localparam int NBYTES =
    (LEN_BYTES > WORD_BYTES) ? LEN_BYTES : WORD_BYTES;

  logic [1:0]  idx;
  logic [31:0] sr;

  assign word      = {data, sr[31:8]};
  assign word_full = load && (idx == 2'(NBYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      sr  <= '0;
    end else if (clear) begin
      idx <= '0;
      sr  <= '0;
    end else if (load) begin
      idx <= idx + 2'd1;
      sr  <= word;
    end
  end

endmodule

// File: rtl/atomrvcore_iccm_loader.sv
// Boot-time ICCM writer: length-prefixed byte stream in, word writes out.
// Define ATOMRV_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
import atomrvcore_loader_pkg::*;

module atomrvcore_iccm_loader #(
  parameter int                   DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] BASE_ADDR = '0,
  parameter int                   DEPTH     = 1024,
  parameter int                   CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  output logic                 IWR_EN_o,
  output logic [DATAWIDTH-1:0] address_o,
  output logic [DATAWIDTH-1:0] DATA_o,
  output logic                 core_rst_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CNT_W-1:0]     word_cnt_o
);

  loader_state_t        state_q, state_d;
  logic                 fire, go, strobe;
  logic                 last_word;
  logic [31:0]          word;
  logic                 word_full;
  logic [DATAWIDTH-1:0] len_q;
  logic [CNT_W-1:0]     cnt_next;

  assign byte_ready_o = (state_q == LEN)
                     || (state_q == DATA)
                     || (state_q == CHK);
  assign fire   = byte_valid_i && byte_ready_o;
  assign strobe = fire && (state_q != CHK);
  assign go     = start_i && ((state_q == IDLE)
                           || (state_q == DONE)
                           || (state_q == ERR));

  assign cnt_next  = word_cnt_o + CNT_W'(1);
  assign last_word = (DATAWIDTH'(cnt_next) == len_q);

  assign IWR_EN_o   = (state_q == WRITE);
  assign done_o     = (state_q == DONE);
  assign err_o      = (state_q == ERR);
  assign core_rst_o = (state_q != DONE);
  assign busy_o     = (state_q == LEN)
                   || (state_q == DATA)
                   || (state_q == WRITE)
                   || (state_q == CHK);

  atomrvcore_word_packer u_packer (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (go),
    .load      (strobe),
    .data      (byte_i),
    .word      (word),
    .word_full (word_full)
  );

`ifdef ATOMRV_LOADER_CHECKSUM_EN
  localparam loader_state_t TAIL = CHK;
  logic [7:0] csum_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csum_q <= '0;
    end else if (go) begin
      csum_q <= '0;
    end else if (fire && (state_q == DATA)) begin
      csum_q <= csum_q ^ byte_i;
    end
  end
`else
  localparam loader_state_t TAIL = DONE;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) state_d = LEN;
      end
      LEN: begin
        if (word_full) begin
          if (word == '0)              state_d = TAIL;
          else if (word > 32'(DEPTH))  state_d = ERR;
          else                         state_d = DATA;
        end
      end
      DATA: begin
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        state_d = last_word ? TAIL : DATA;
      end
`ifdef ATOMRV_LOADER_CHECKSUM_EN
      CHK: begin
        if (fire) state_d = (byte_i == csum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Address/data are latched on the final data byte so they are stable
  // for the whole WRITE cycle and hold afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_cnt_o <= '0;
      address_o  <= BASE_ADDR;
      DATA_o     <= '0;
      len_q      <= '0;
    end else begin
      if (go) begin
        word_cnt_o <= '0;
        address_o  <= BASE_ADDR;
      end
      if ((state_q == LEN) && word_full) begin
        len_q <= DATAWIDTH'(word);
      end
      if ((state_q == DATA) && word_full) begin
        address_o <= BASE_ADDR
                   + (DATAWIDTH'(word_cnt_o) << 2);
        DATA_o    <= DATAWIDTH'(word);
      end
      if (state_q == WRITE) begin
        word_cnt_o <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_atomrvcore_iccm_loader.sv
// Directed bench for atomrvcore_iccm_loader; checksum steps run only
// when ATOMRV_LOADER_CHECKSUM_EN is defined.
module tb_atomrvcore_iccm_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bdata;
  logic        bvalid;
  logic        ready;
  logic        iwr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];
  int          wr_n = 0;
  logic        prev_iwr = 1'b0;

  atomrvcore_iccm_loader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .byte_i       (bdata),
    .byte_valid_i (bvalid),
    .byte_ready_o (ready),
    .IWR_EN_o     (iwr),
    .address_o    (addr),
    .DATA_o       (wdata),
    .core_rst_o   (core_rst),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .word_cnt_o   (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (iwr === 1'b1) begin
      chk("ready_in_write", 32'(ready), 32'd0);
      chk("iwr_one_cycle", 32'(prev_iwr), 32'd0);
      if (wr_n < 8) begin
        wr_addr[wr_n] = addr;
        wr_data[wr_n] = wdata;
      end
      wr_n++;
    end
    prev_iwr = iwr;
  end

  // Called at a negedge; returns at a negedge.
  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    bdata  = b;
    bvalid = 1'b1;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("ready_timeout", 32'(ready), 32'd1);
    else @(posedge clk);
    @(negedge clk);
    bvalid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3,
                       input int gap);
    send(b0, gap);
    send(b1, gap);
    send(b2, gap);
    send(b3, gap);
  endtask

  task automatic send_csum(input logic [7:0] c);
`ifdef ATOMRV_LOADER_CHECKSUM_EN
    send(c, 0);
`else
    bdata = c;
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic reset_checks(input string t);
    chk({t, "_ready"}, 32'(ready), 32'd0);
    chk({t, "_iwr"}, 32'(iwr), 32'd0);
    chk({t, "_addr"}, addr, 32'h0);
    chk({t, "_data"}, wdata, 32'h0);
    chk({t, "_core_rst"}, 32'(core_rst), 32'd1);
    chk({t, "_busy"}, 32'(busy), 32'd0);
    chk({t, "_done"}, 32'(done), 32'd0);
    chk({t, "_err"}, 32'(err), 32'd0);
    chk({t, "_cnt"}, 32'(cnt), 32'd0);
  endtask

  task automatic two_word_image(input int gap);
    send4(8'h02, 8'h00, 8'h00, 8'h00, gap);
    send4(8'h13, 8'h00, 8'h00, 8'h00, gap);
    send4(8'h93, 8'h00, 8'h10, 8'h00, gap);
    send_csum(8'h90);
    @(negedge clk);
  endtask

  task automatic check_two_words(input string t);
    chk({t, "_wr_n"}, 32'(wr_n), 32'd2);
    chk({t, "_a0"}, wr_addr[0], 32'h0);
    chk({t, "_d0"}, wr_data[0], 32'h0000_0013);
    chk({t, "_a1"}, wr_addr[1], 32'h4);
    chk({t, "_d1"}, wr_data[1], 32'h0010_0093);
    chk({t, "_done"}, 32'(done), 32'd1);
    chk({t, "_core_rst"}, 32'(core_rst), 32'd0);
    chk({t, "_busy"}, 32'(busy), 32'd0);
    chk({t, "_cnt"}, 32'(cnt), 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bvalid = 1'b0;
    bdata  = 8'h00;
    repeat (2) @(negedge clk);
    reset_checks("rst");
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back two-word image
    pulse_start();
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_ready", 32'(ready), 32'd1);
    wr_n = 0;
    two_word_image(0);
    check_two_words("img");
    chk("img_hold_addr", addr, 32'h4);
    chk("img_hold_data", wdata, 32'h0010_0093);

    // Extra bytes in DONE are backpressured
    bdata  = 8'h55;
    bvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("done_ready", 32'(ready), 32'd0);
    chk("done_cnt", 32'(cnt), 32'd2);
    bvalid = 1'b0;

    // Restart from DONE re-asserts core reset
    pulse_start();
    chk("rearm_core_rst", 32'(core_rst), 32'd1);
    chk("rearm_busy", 32'(busy), 32'd1);
    chk("rearm_cnt", 32'(cnt), 32'd0);
    chk("rearm_addr", addr, 32'h0);
    chk("rearm_done", 32'(done), 32'd0);

    // Same image with gapped byte_valid
    wr_n = 0;
    two_word_image(1);
    check_two_words("gap");

    // Oversize length aborts
    pulse_start();
    wr_n = 0;
    send4(8'h01, 8'h04, 8'h00, 8'h00, 0);
    chk("big_err", 32'(err), 32'd1);
    chk("big_core_rst", 32'(core_rst), 32'd1);
    chk("big_busy", 32'(busy), 32'd0);
    chk("big_ready", 32'(ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("big_no_write", 32'(wr_n), 32'd0);
    pulse_start();
    chk("big_rearm_busy", 32'(busy), 32'd1);
    chk("big_rearm_err", 32'(err), 32'd0);
    chk("big_rearm_ready", 32'(ready), 32'd1);

    // Reset in the middle of word 2 of a 3-word image
    send4(8'h03, 8'h00, 8'h00, 8'h00, 0);
    send4(8'h11, 8'h22, 8'h33, 8'h44, 0);
    send(8'h55, 0);
    send(8'h66, 0);
    chk("mid_wr_n", 32'(wr_n), 32'd1);
    chk("mid_d0", wr_data[0], 32'h4433_2211);
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    wr_n = 0;
    send4(8'h01, 8'h00, 8'h00, 8'h00, 0);
    send4(8'hAA, 8'hBB, 8'hCC, 8'hDD, 0);
    send_csum(8'h00);
    @(negedge clk);
    chk("fresh_wr_n", 32'(wr_n), 32'd1);
    chk("fresh_a0", wr_addr[0], 32'h0);
    chk("fresh_d0", wr_data[0], 32'hDDCC_BBAA);
    chk("fresh_done", 32'(done), 32'd1);
    chk("fresh_cnt", 32'(cnt), 32'd1);

    // Empty image
    pulse_start();
    wr_n = 0;
    send4(8'h00, 8'h00, 8'h00, 8'h00, 0);
    send_csum(8'h00);
    @(negedge clk);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_cnt", 32'(cnt), 32'd0);
    chk("empty_wr_n", 32'(wr_n), 32'd0);

`ifdef ATOMRV_LOADER_CHECKSUM_EN
    pulse_start();
    send4(8'h01, 8'h00, 8'h00, 8'h00, 0);
    send4(8'h13, 8'h00, 8'h00, 8'h00, 0);
    send(8'h13, 0);
    @(negedge clk);
    chk("csum_ok_done", 32'(done), 32'd1);
    pulse_start();
    send4(8'h01, 8'h00, 8'h00, 8'h00, 0);
    send4(8'h13, 8'h00, 8'h00, 8'h00, 0);
    send(8'h12, 0);
    @(negedge clk);
    chk("csum_bad_err", 32'(err), 32'd1);
    chk("csum_bad_core", 32'(core_rst), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
